// File: rtl/axi4l_stream_fifo.sv
// AXI4-lite slave bridging single-register writes into a TX stream FIFO and
// single-register reads out of an RX stream FIFO, with sticky overflow and
// underflow flags.

// Circular buffer of 32-bit words with occupancy count; the head reads as 0 when empty.
module axi4l_stream_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          aclk,
    input  logic          areset_n,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   head,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guards keep the level inside 0..DEPTH even if a caller misbehaves.
    assign do_push = push && (level != LW'(DEPTH));
    assign do_pop  = pop && (level != '0);
    assign head    = (level != '0) ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: the level masks stale contents.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module axi4l_stream_fifo #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          aclk,
    input  logic          areset_n,
    input  logic          awvalid,
    output logic          awready,
    input  logic [2:0]    awprot,
    input  logic          wvalid,
    output logic          wready,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    output logic          bvalid,
    input  logic          bready,
    output logic [1:0]    bresp,
    input  logic          arvalid,
    output logic          arready,
    input  logic [2:0]    arprot,
    output logic          rvalid,
    input  logic          rready,
    output logic [31:0]   rdata,
    output logic [1:0]    rresp,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic [31:0]   tx_data_o,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    input  logic [31:0]   rx_data_i,
    output logic [LW-1:0] tx_level_o,
    output logic [LW-1:0] rx_level_o,
    output logic          tx_ovf_o,
    output logic          rx_udf_o
);
    logic        aw_set;
    logic        w_set;
    logic        ar_set;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] tx_word;
    logic [31:0] rx_head;
    logic        wr_eval;
    logic        tx_full;
    logic        tx_push;
    logic        tx_pop;
    logic        rx_push;
    logic        rx_pop;
    logic        ar_hs;
    logic        unused_prot;

    assign unused_prot = ^{awprot, arprot};

    assign awready = !aw_set;
    assign wready  = !w_set;
    assign arready = !ar_set;

    // A write is judged exactly once: both halves captured and no response outstanding.
    assign wr_eval = aw_set && w_set && !bvalid;
    assign tx_full = (tx_level_o == LW'(DEPTH));
    assign tx_push = wr_eval && !tx_full && (wstrb_q != 4'b0000);

    assign tx_valid_o = (tx_level_o != '0);
    assign tx_pop     = tx_valid_o && tx_ready_i;
    assign rx_ready_o = (rx_level_o != LW'(DEPTH));
    assign rx_push    = rx_valid_i && rx_ready_o;
    assign ar_hs      = arvalid && arready;
    assign rx_pop     = ar_hs && (rx_level_o != '0);

    // Bytes with a clear strobe bit are zeroed before entering the TX FIFO.
    always_comb begin
        tx_word = '0;
        for (int i = 0; i < 4; i++)
            tx_word[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : 8'h00;
    end

    // Write channel: independent AW/W capture, one evaluation, B held until accepted.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_set   <= 1'b0;
            w_set    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            tx_ovf_o <= 1'b0;
        end else if (bvalid && bready) begin
            aw_set <= 1'b0;
            w_set  <= 1'b0;
            bvalid <= 1'b0;
        end else begin
            if (awvalid && awready) aw_set <= 1'b1;
            if (wvalid && wready) begin
                w_set   <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (wr_eval) begin
                bvalid <= 1'b1;
                bresp  <= tx_full ? 2'b10 : 2'b00;
                if (tx_full) tx_ovf_o <= 1'b1;
            end
        end
    end

    // Read channel: the RX head is popped on the AR handshake and held in rdata until R completes.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            ar_set   <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
            rx_udf_o <= 1'b0;
        end else if (rvalid && rready) begin
            ar_set <= 1'b0;
            rvalid <= 1'b0;
        end else if (ar_hs) begin
            ar_set <= 1'b1;
            rvalid <= 1'b1;
            if (rx_level_o != '0) begin
                rdata <= rx_head;
                rresp <= 2'b00;
            end else begin
                rdata    <= '0;
                rresp    <= 2'b10;
                rx_udf_o <= 1'b1;
            end
        end
    end

    axi4l_stream_fifo_buf #(.DEPTH(DEPTH), .LW(LW)) u_tx_fifo (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .push      (tx_push),
        .push_data (tx_word),
        .pop       (tx_pop),
        .head      (tx_data_o),
        .level     (tx_level_o)
    );

    axi4l_stream_fifo_buf #(.DEPTH(DEPTH), .LW(LW)) u_rx_fifo (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .push      (rx_push),
        .push_data (rx_data_i),
        .pop       (rx_pop),
        .head      (rx_head),
        .level     (rx_level_o)
    );
endmodule

// File: tb/tb_axi4l_stream_fifo.sv
// Directed bench for axi4l_stream_fifo (DEPTH=8).
module tb_axi4l_stream_fifo;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          aclk = 1'b0;
    logic          areset_n = 1'b0;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [2:0]    awprot, arprot;
    logic [31:0]   wdata, rdata, tx_data_o, rx_data_i;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          tx_valid_o, tx_ready_i, rx_valid_i, rx_ready_o;
    logic [LW-1:0] tx_level_o, rx_level_o;
    logic          tx_ovf_o, rx_udf_o;

    int errors = 0;
    int checks = 0;

    axi4l_stream_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awvalid(awvalid), .awready(awready), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
        .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
        .tx_ovf_o(tx_ovf_o), .rx_udf_o(rx_udf_o)
    );

    always #5 aclk = ~aclk;

    task automatic idle_inputs();
        awvalid = 0; wvalid = 0; arvalid = 0; rx_valid_i = 0; tx_ready_i = 0;
        bready = 1; rready = 1; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
        rx_data_i = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        areset_n = 0;
        repeat (2) @(negedge aclk);
        areset_n = 1;
    endtask

    // Drives AW and W with independent start delays, waits for B.
    task automatic do_write(input logic [31:0] d, input logic [3:0] s, input int aw_dly,
                            input int w_dly, output logic [1:0] resp, output bit ok);
        bit aw_done;
        bit w_done;
        aw_done = 0; w_done = 0; ok = 0; resp = 2'bxx;
        wdata = d; wstrb = s;
        for (int cyc = 0; cyc < 30 && !ok; cyc++) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            if (bvalid && bready) begin resp = bresp; ok = 1; end
            @(negedge aclk);
        end
        awvalid = 0; wvalid = 0;
    endtask

    task automatic do_read(output logic [31:0] data, output logic [1:0] resp, output bit ok);
        bit ar_done;
        ar_done = 0; ok = 0; data = 'x; resp = 2'bxx;
        for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
            arvalid = !ar_done;
            if (arvalid && arready) ar_done = 1;
            if (rvalid && rready) begin data = rdata; resp = rresp; ok = 1; end
            @(negedge aclk);
        end
        arvalid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        areset_n = 0;
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready, rx_ready_o} !== 4'b1111) begin
            errors++; $display("FAIL reset_ready: got %b want 1111", {awready, wready, arready, rx_ready_o});
        end
        checks++;
        if ({bvalid, rvalid, bresp, rresp, tx_valid_o} !== 7'b0) begin
            errors++; $display("FAIL reset_resp: got %b want 0000000", {bvalid, rvalid, bresp, rresp, tx_valid_o});
        end
        checks++;
        if ({rdata, tx_data_o} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got rdata=%h tx_data=%h want 0", rdata, tx_data_o);
        end
        checks++;
        if ({tx_level_o, rx_level_o, tx_ovf_o, rx_udf_o} !== '0) begin
            errors++; $display("FAIL reset_levels: got tx=%0d rx=%0d ovf=%b udf=%b want 0", tx_level_o, rx_level_o, tx_ovf_o, rx_udf_o);
        end
        @(negedge aclk);
        areset_n = 1;
    endtask

    task automatic test_strobe_write();
        logic [1:0] resp;
        bit ok;
        apply_reset();
        do_write(32'hA1B2C3D4, 4'b0101, 0, 2, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00) begin
            errors++; $display("FAIL strobe_resp: got ok=%0b resp=%b want ok=1 resp=00", ok, resp);
        end
        checks++;
        if (tx_data_o !== 32'h00B200D4 || tx_level_o !== 4'd1 || tx_valid_o !== 1'b1) begin
            errors++; $display("FAIL strobe_push: got data=%h lvl=%0d vld=%b want 00b200d4/1/1", tx_data_o, tx_level_o, tx_valid_o);
        end
        do_write(32'hFFFFFFFF, 4'b0000, 0, 0, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00 || tx_level_o !== 4'd1 || tx_data_o !== 32'h00B200D4) begin
            errors++; $display("FAIL zero_strobe: got ok=%0b resp=%b lvl=%0d data=%h want 1/00/1/00b200d4", ok, resp, tx_level_o, tx_data_o);
        end
        do_write(32'h11223344, 4'b1111, 3, 0, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00 || tx_level_o !== 4'd2) begin
            errors++; $display("FAIL w_before_aw: got ok=%0b resp=%b lvl=%0d want 1/00/2", ok, resp, tx_level_o);
        end
        tx_ready_i = 1;
        @(negedge aclk);
        tx_ready_i = 0;
        checks++;
        if (tx_data_o !== 32'h11223344 || tx_level_o !== 4'd1) begin
            errors++; $display("FAIL tx_pop: got data=%h lvl=%0d want 11223344/1", tx_data_o, tx_level_o);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] resp;
        bit ok;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_write(32'hD0000000 + i, 4'hF, 0, 0, resp, ok);
            checks++;
            if (!ok || resp !== ((i < 8) ? 2'b00 : 2'b10)) begin
                errors++; $display("FAIL ovf_write%0d: got ok=%0b resp=%b want resp=%b", i + 1, ok, resp, (i < 8) ? 2'b00 : 2'b10);
            end
            if (i == 7) begin
                checks++;
                if (tx_ovf_o !== 1'b0) begin
                    errors++; $display("FAIL ovf_early: got %b want 0", tx_ovf_o);
                end
            end
        end
        checks++;
        if (tx_ovf_o !== 1'b1 || tx_level_o !== 4'd8 || tx_data_o !== 32'hD0000000) begin
            errors++; $display("FAIL ovf_state: got ovf=%b lvl=%0d data=%h want 1/8/d0000000", tx_ovf_o, tx_level_o, tx_data_o);
        end
        tx_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== 32'hD0000000 + i) begin
                errors++; $display("FAIL drain%0d: got vld=%b data=%h want 1/%h", i, tx_valid_o, tx_data_o, 32'hD0000000 + i);
            end
            @(negedge aclk);
        end
        tx_ready_i = 0;
        checks++;
        if (tx_level_o !== 4'd0 || tx_valid_o !== 1'b0 || tx_ovf_o !== 1'b1) begin
            errors++; $display("FAIL drained: got lvl=%0d vld=%b ovf=%b want 0/0/1", tx_level_o, tx_valid_o, tx_ovf_o);
        end
        do_write(32'hE0E0E0E0, 4'hF, 0, 0, resp, ok);
        checks++;
        if (!ok || resp !== 2'b00 || tx_level_o !== 4'd1 || tx_data_o !== 32'hE0E0E0E0) begin
            errors++; $display("FAIL wrap_write: got resp=%b lvl=%0d data=%h want 00/1/e0e0e0e0", resp, tx_level_o, tx_data_o);
        end
    endtask

    task automatic test_rx_read();
        logic [31:0] d;
        logic [1:0]  resp;
        bit ok;
        apply_reset();
        do_read(d, resp, ok);
        checks++;
        if (!ok || d !== 32'h0 || resp !== 2'b10 || rx_udf_o !== 1'b1) begin
            errors++; $display("FAIL udf_read: got ok=%0b data=%h resp=%b udf=%b want 1/0/10/1", ok, d, resp, rx_udf_o);
        end
        rx_valid_i = 1; rx_data_i = 32'h12345678;
        @(negedge aclk);
        rx_valid_i = 0;
        checks++;
        if (rx_level_o !== 4'd1) begin
            errors++; $display("FAIL rx_push: got lvl=%0d want 1", rx_level_o);
        end
        do_read(d, resp, ok);
        checks++;
        if (!ok || d !== 32'h12345678 || resp !== 2'b00 || rx_level_o !== 4'd0 || rx_udf_o !== 1'b1) begin
            errors++; $display("FAIL rx_read: got data=%h resp=%b lvl=%0d udf=%b want 12345678/00/0/1", d, resp, rx_level_o, rx_udf_o);
        end
    endtask

    task automatic test_rx_full();
        logic [31:0] d;
        logic [1:0]  resp;
        bit ok;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            rx_valid_i = 1; rx_data_i = 32'hC0 + i;
            @(negedge aclk);
        end
        rx_data_i = 32'hC8;
        @(negedge aclk);
        checks++;
        if (rx_ready_o !== 1'b0 || rx_level_o !== 4'd8) begin
            errors++; $display("FAIL rx_full: got rdy=%b lvl=%0d want 0/8", rx_ready_o, rx_level_o);
        end
        arvalid = 1;
        @(negedge aclk);
        arvalid = 0;
        checks++;
        if (rx_ready_o !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'hC0 || rx_level_o !== 4'd7) begin
            errors++; $display("FAIL rx_pop_full: got rdy=%b rvalid=%b rdata=%h lvl=%0d want 1/1/c0/7", rx_ready_o, rvalid, rdata, rx_level_o);
        end
        @(negedge aclk);
        rx_valid_i = 0;
        checks++;
        if (rx_level_o !== 4'd8) begin
            errors++; $display("FAIL rx_ninth: got lvl=%0d want 8", rx_level_o);
        end
        for (int i = 1; i < 9; i++) begin
            do_read(d, resp, ok);
            checks++;
            if (!ok || d !== 32'hC0 + i || resp !== 2'b00) begin
                errors++; $display("FAIL rx_order%0d: got ok=%0b data=%h resp=%b want %h/00", i, ok, d, resp, 32'hC0 + i);
            end
        end
        checks++;
        if (rx_level_o !== 4'd0) begin
            errors++; $display("FAIL rx_empty_end: got lvl=%0d want 0", rx_level_o);
        end
    endtask

    task automatic test_bready_stall();
        apply_reset();
        bready = 0;
        awvalid = 1; wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        for (int n = 0; n < 10 && !bvalid; n++) @(negedge aclk);
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL stall_bvalid_timeout: got bvalid=%b want 1", bvalid);
        end
        awvalid = 1; wdata = 32'h66666666;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) begin
                errors++; $display("FAIL stall%0d: got bvalid=%b bresp=%b awready=%b want 1/00/0", k, bvalid, bresp, awready);
            end
            @(negedge aclk);
        end
        bready = 1;
        @(negedge aclk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++; $display("FAIL stall_release: got bvalid=%b awready=%b want 0/1", bvalid, awready);
        end
        @(negedge aclk);
        checks++;
        if (awready !== 1'b0) begin
            errors++; $display("FAIL second_aw: got awready=%b want 0", awready);
        end
        awvalid = 0; wvalid = 1;
        @(negedge aclk);
        wvalid = 0;
        for (int n = 0; n < 10 && !bvalid; n++) @(negedge aclk);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++; $display("FAIL second_b: got bvalid=%b bresp=%b want 1/00", bvalid, bresp);
        end
        @(negedge aclk);
        checks++;
        if (tx_level_o !== 4'd2 || tx_data_o !== 32'h55555555) begin
            errors++; $display("FAIL stall_level: got lvl=%0d data=%h want 2/55555555", tx_level_o, tx_data_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        bit ok;
        int stray;
        apply_reset();
        for (int i = 0; i < 3; i++) do_write(32'hAB00 + i, 4'hF, 0, 0, resp, ok);
        checks++;
        if (tx_level_o !== 4'd3) begin
            errors++; $display("FAIL mid_setup: got lvl=%0d want 3", tx_level_o);
        end
        rready = 0;
        arvalid = 1;
        @(negedge aclk);
        arvalid = 0;
        @(negedge aclk);
        checks++;
        if (rvalid !== 1'b1 || rx_udf_o !== 1'b1) begin
            errors++; $display("FAIL mid_pending: got rvalid=%b udf=%b want 1/1", rvalid, rx_udf_o);
        end
        areset_n = 0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || tx_level_o !== 4'd0 || rx_level_o !== 4'd0 ||
            rx_udf_o !== 1'b0 || tx_ovf_o !== 1'b0 || tx_data_o !== 32'h0 || tx_valid_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got rvalid=%b arready=%b tx=%0d rx=%0d udf=%b ovf=%b txd=%h want 0/1/0/0/0/0/0",
                               rvalid, arready, tx_level_o, rx_level_o, rx_udf_o, tx_ovf_o, tx_data_o);
        end
        @(negedge aclk);
        rready = 1; rx_valid_i = 1; rx_data_i = 32'h77;
        areset_n = 1;
        @(negedge aclk);
        rx_valid_i = 0;
        checks++;
        if (rx_level_o !== 4'd1) begin
            errors++; $display("FAIL first_edge: got rx lvl=%0d want 1", rx_level_o);
        end
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            if (rvalid || bvalid) stray++;
            @(negedge aclk);
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL stray_resp: got %0d cycles with a response want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_strobe_write();
        test_overflow();
        test_rx_read();
        test_rx_full();
        test_bready_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
